// File: rtl/jt1942_dwnld.sv
// ROM download writer: packs host bytes into 16-bit SDRAM words behind a
// request/ack handshake with a one-entry skid, routes the PROM region to
// per-PROM write strobes, and owns the downloading/done flags.
module jt1942_dwnld #(
    parameter logic [21:0] PROM_START = 22'h2A000,
    parameter int          PROM_COUNT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ioctl_downloading,
    input  logic [21:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    output logic                  sdram_we,
    output logic [21:0]           sdram_addr,
    output logic [15:0]           sdram_din,
    input  logic                  sdram_ack,
    output logic [7:0]            prog_addr,
    output logic [3:0]            prog_din,
    output logic [PROM_COUNT-1:0] prom_we,
    output logic                  downloading,
    output logic                  dwnld_done,
    output logic                  overflow
);
    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] din;
    } wr_req_t;

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [22:0] PROM_END = 23'(PROM_START) + 23'(256 * PROM_COUNT);

    state_t      state_q, state_d;
    logic        half_valid, dl_prev;
    logic [7:0]  lo_byte;
    logic [20:0] half_addr;
    logic        skid_v;
    wr_req_t     skid, w;

    logic        wr_ok, in_sdram, in_prom, odd_word, even_byte, flush, w_vld;
    logic [21:0] prom_off;
    logic        load_out, load_from_skid, skid_load, skid_clr, ovf_set;
    logic        dl_next;

    assign wr_ok     = ioctl_wr & ioctl_downloading;
    assign in_sdram  = ioctl_addr < PROM_START;
    assign in_prom   = !in_sdram && ({1'b0, ioctl_addr} < PROM_END);
    assign prom_off  = ioctl_addr - PROM_START;
    assign odd_word  = wr_ok & in_sdram & ioctl_addr[0];
    assign even_byte = wr_ok & in_sdram & ~ioctl_addr[0];
    // A trailing even byte is flushed with 0xFF in the odd lane when the host window closes.
    assign flush     = dl_prev & ~ioctl_downloading & half_valid;
    assign w_vld     = odd_word | flush;
    assign w.addr    = odd_word ? {1'b0, ioctl_addr[21:1]} : {1'b0, half_addr};
    assign w.din     = odd_word ? {ioctl_data, half_valid ? lo_byte : 8'hFF}
                                : {8'hFF, lo_byte};
    assign sdram_we  = (state_q == WRITE);

    // Half-word capture and download-window edge tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            half_valid <= 1'b0;
            lo_byte    <= '0;
            half_addr  <= '0;
            dl_prev    <= 1'b0;
        end else begin
            dl_prev <= ioctl_downloading;
            if (even_byte) begin
                half_valid <= 1'b1;
                lo_byte    <= ioctl_data;
                half_addr  <= ioctl_addr[21:1];
            end else if (w_vld) begin
                half_valid <= 1'b0;
            end
        end
    end

    // Write engine next state: skid word always issues before a newly completed word
    always_comb begin
        state_d        = state_q;
        load_out       = 1'b0;
        load_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        ovf_set        = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_vld) begin
                    load_out = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (sdram_ack) begin
                    if (skid_v) begin
                        load_out       = 1'b1;
                        load_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        skid_load      = w_vld;
                    end else if (w_vld) begin
                        load_out = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (w_vld) begin
                    if (skid_v) ovf_set   = 1'b1;
                    else        skid_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write engine registers: state, output word, skid slot, overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sdram_addr <= '0;
            sdram_din  <= '0;
            skid_v     <= 1'b0;
            skid       <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                sdram_addr <= load_from_skid ? skid.addr : w.addr;
                sdram_din  <= load_from_skid ? skid.din  : w.din;
            end
            if (skid_load) begin
                skid   <= w;
                skid_v <= 1'b1;
            end else if (skid_clr) begin
                skid_v <= 1'b0;
            end
            if (ovf_set) overflow <= 1'b1;
        end
    end

    // PROM routing: one-cycle strobe, address/data held until the next PROM byte
    always_ff @(posedge clk) begin
        if (rst) begin
            prom_we   <= '0;
            prog_addr <= '0;
            prog_din  <= '0;
        end else begin
            prom_we <= '0;
            if (wr_ok && in_prom) begin
                prom_we   <= PROM_COUNT'(1) << prom_off[11:8];
                prog_addr <= prom_off[7:0];
                prog_din  <= ioctl_data[3:0];
            end
        end
    end

    // downloading stays up until the host window is closed and every write has drained
    assign dl_next = ioctl_downloading |
                     (downloading & ~(~half_valid & (state_q == IDLE) & ~skid_v));

    // Download flag and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            downloading <= 1'b0;
            dwnld_done  <= 1'b0;
        end else begin
            downloading <= dl_next;
            dwnld_done  <= downloading & ~dl_next;
        end
    end
endmodule

// File: tb/tb_jt1942_dwnld.sv
// Directed bench for jt1942_dwnld: single word, back-pressure/overflow,
// PROM routing, trailing-byte flush, reset mid-write, stray ack.
module tb_jt1942_dwnld;
    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_we;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_ack;
    logic [7:0]  prog_addr;
    logic [3:0]  prog_din;
    logic [9:0]  prom_we;
    logic        downloading;
    logic        dwnld_done;
    logic        overflow;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    jt1942_dwnld dut (
        .clk               (clk),
        .rst               (rst),
        .ioctl_downloading (ioctl_downloading),
        .ioctl_addr        (ioctl_addr),
        .ioctl_data        (ioctl_data),
        .ioctl_wr          (ioctl_wr),
        .sdram_we          (sdram_we),
        .sdram_addr        (sdram_addr),
        .sdram_din         (sdram_din),
        .sdram_ack         (sdram_ack),
        .prog_addr         (prog_addr),
        .prog_din          (prog_din),
        .prom_we           (prom_we),
        .downloading       (downloading),
        .dwnld_done        (dwnld_done),
        .overflow          (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ioctl_downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; sdram_ack = 1'b0;
        repeat (3) tick();
        chk("rst_we",   32'(sdram_we), 32'h0);
        chk("rst_addr", 32'(sdram_addr), 32'h0);
        chk("rst_din",  32'(sdram_din), 32'h0);
        chk("rst_prom", 32'(prom_we), 32'h0);
        chk("rst_dl",   32'(downloading), 32'h0);
        chk("rst_done", 32'(dwnld_done), 32'h0);
        chk("rst_ovf",  32'(overflow), 32'h0);
        rst = 1'b0;

        // write ignored outside the download window
        wr_byte(22'h000001, 8'h99);
        chk("idle_wr_we", 32'(sdram_we), 32'h0);

        ioctl_downloading = 1'b1;
        tick();
        chk("dl_rise", 32'(downloading), 32'h1);

        // single word, ack 3 cycles after the request
        wr_byte(22'h000000, 8'h34);
        chk("sw_even_we", 32'(sdram_we), 32'h0);
        wr_byte(22'h000001, 8'h12);
        chk("sw_we",   32'(sdram_we), 32'h1);
        chk("sw_addr", 32'(sdram_addr), 32'h0);
        chk("sw_din",  32'(sdram_din), 32'h1234);
        tick(); tick();
        chk("sw_hold", 32'(sdram_we), 32'h1);
        ack();
        chk("sw_drop", 32'(sdram_we), 32'h0);

        // stray ack in IDLE
        ack();
        chk("stray_we",  32'(sdram_we), 32'h0);
        chk("stray_ovf", 32'(overflow), 32'h0);

        // back-pressure: word1 on bus, word2 skid, word3 dropped
        wr_byte(22'h000020, 8'hAA);
        wr_byte(22'h000021, 8'hBB);
        chk("bp_w1_addr", 32'(sdram_addr), 32'h10);
        wr_byte(22'h000022, 8'hCC);
        wr_byte(22'h000023, 8'hDD);
        wr_byte(22'h000024, 8'hEE);
        wr_byte(22'h000025, 8'hFF);
        chk("bp_ovf", 32'(overflow), 32'h1);
        repeat (14) tick();
        chk("bp_hold_we",   32'(sdram_we), 32'h1);
        chk("bp_hold_addr", 32'(sdram_addr), 32'h10);
        chk("bp_hold_din",  32'(sdram_din), 32'hBBAA);
        ack();
        chk("bp_w2_we",   32'(sdram_we), 32'h1);
        chk("bp_w2_addr", 32'(sdram_addr), 32'h11);
        chk("bp_w2_din",  32'(sdram_din), 32'hDDCC);
        ack();
        chk("bp_end_we",  32'(sdram_we), 32'h0);
        chk("bp_ovf_stk", 32'(overflow), 32'h1);

        // PROM routing
        wr_byte(22'h02A305, 8'hA7);
        chk("prom_we",   32'(prom_we), 32'h008);
        chk("prom_addr", 32'(prog_addr), 32'h05);
        chk("prom_din",  32'(prog_din), 32'h7);
        chk("prom_sd",   32'(sdram_we), 32'h0);
        tick();
        chk("prom_pulse", 32'(prom_we), 32'h0);
        chk("prom_hold",  32'(prog_addr), 32'h05);
        wr_byte(22'h02AA00, 8'h55);
        chk("prom_end_we",   32'(prom_we), 32'h0);
        chk("prom_end_addr", 32'(prog_addr), 32'h05);

        // trailing even byte flushed at end of download
        wr_byte(22'h000010, 8'h5C);
        ioctl_downloading = 1'b0;
        tick();
        chk("fl_we",   32'(sdram_we), 32'h1);
        chk("fl_addr", 32'(sdram_addr), 32'h8);
        chk("fl_din",  32'(sdram_din), 32'hFF5C);
        tick(); tick();
        chk("fl_dl",   32'(downloading), 32'h1);
        chk("fl_nodn", 32'(dwnld_done), 32'h0);
        ack();
        chk("fl_drop", 32'(sdram_we), 32'h0);
        chk("fl_dl2",  32'(downloading), 32'h1);
        tick();
        chk("fl_dl_low", 32'(downloading), 32'h0);
        chk("fl_done",   32'(dwnld_done), 32'h1);
        tick();
        chk("fl_done_1", 32'(dwnld_done), 32'h0);

        // reset while a write is pending and the skid is full
        ioctl_downloading = 1'b1;
        tick();
        wr_byte(22'h000030, 8'h11);
        wr_byte(22'h000031, 8'h22);
        wr_byte(22'h000032, 8'h33);
        wr_byte(22'h000033, 8'h44);
        chk("rmw_we_pre", 32'(sdram_we), 32'h1);
        rst = 1'b1;
        ioctl_downloading = 1'b0;
        tick();
        chk("rmw_we",   32'(sdram_we), 32'h0);
        chk("rmw_addr", 32'(sdram_addr), 32'h0);
        chk("rmw_din",  32'(sdram_din), 32'h0);
        chk("rmw_dl",   32'(downloading), 32'h0);
        chk("rmw_ovf",  32'(overflow), 32'h0);
        chk("rmw_padr", 32'(prog_addr), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("rmw_after_we", 32'(sdram_we), 32'h0);
        chk("rmw_after_dn", 32'(dwnld_done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
